iob_cfg_loader: RTL and testbench
=================================

Name: iob_cfg_loader

Overview:
- Serial configuration loader that programs the per-pad mode bits of a bank of NUM_IOB IO blocks.
- Per pad, it sets the 2-bit tristate-mux select and the 1-bit direct-or-registered input select.
- It hunts for a sync word on a 1-bit config stream, shifts in a payload frame and checks even parity.
- On a good frame it commits the payload atomically to the outputs that drive each IO block's TSMUX/DORREG fields. It sits directly upstream of the IO block bank.

Parameters:
- NUM_IOB, 6, number of IO blocks configured per frame.
- SYNC_WORD, 8'hA5, frame start pattern, received MSB first.

Ports:
- IOCLK  input  1  clock; all state updates on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- CFG_EN  input  1  qualifies CFG_DIN; a bit is consumed only on edges where CFG_EN=1.
- CFG_DIN  input  1  serial config data.
- CFG_ABORT  input  1  synchronous abort; discards any frame in progress.
- TSMUX_O  output  2*NUM_IOB  tristate-mux select per IOB; IOB i uses bits [2i+1:2i].
- DORREG_O  output  NUM_IOB  input-path select per IOB; IOB i uses bit i.
- CFG_BUSY  output  1  high while a frame is being loaded or committed.
- CFG_DONE  output  1  last frame committed successfully.
- CFG_ERR  output  1  last frame failed parity.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - TSMUX_O=0, so every pad is high-Z.
  - DORREG_O=0, CFG_BUSY=0, CFG_DONE=0, CFG_ERR=0.
  - FSM enters HUNT; sync window, shadow register and bit counter clear.
- Reset release takes effect on the first IOCLK edge with RSTN=1.
- FSM states: HUNT, LOAD, PARITY, COMMIT.
- HUNT:
  - Each consumed bit shifts into an 8-bit window (new bit enters at LSB).
  - If the updated window equals SYNC_WORD, go to LOAD at that edge, clear the counter and clear CFG_DONE/CFG_ERR.
  - Overlapping sync patterns are detected; the window is not cleared between mismatches.
- LOAD:
  - Consume exactly 3*NUM_IOB payload bits, then go to PARITY.
  - Arrival order: IOB 0 first. Within each IOB: TSMUX[1], then TSMUX[0], then DORREG.
  - The running XOR of payload bits is tracked.
- PARITY:
  - Consume one bit; the frame is good if running XOR ^ bit == 0 (even parity over payload plus parity bit).
  - Go to COMMIT.
- COMMIT (exactly one cycle; CFG_EN and CFG_DIN ignored):
  - Good frame: TSMUX_O/DORREG_O load from the shadow register and CFG_DONE=1, all on the same edge.
  - Bad frame: outputs unchanged and CFG_ERR=1.
  - Either way, the window clears and the FSM returns to HUNT.
- Latency: outputs change on the edge after the parity bit is consumed; no partial update is ever visible.
- CFG_EN=0 in any state except COMMIT: state, counter, window and shadow hold (stall). Stalls of any length are legal.
- CFG_BUSY=1 in LOAD, PARITY and COMMIT; 0 in HUNT.
- CFG_DONE/CFG_ERR are levels. They hold until the next sync match or reset, and are never both 1.
- CFG_ABORT=1 at an edge, in any state:
  - Return to HUNT; clear window, counter and shadow.
  - Active outputs and CFG_DONE/CFG_ERR unchanged.
  - Abort has priority over CFG_EN and over COMMIT (an abort during COMMIT suppresses the commit).
- Bit counter width is clog2(3*NUM_IOB+1). No wrap: terminal count forces the transition to PARITY.
- Reset mid-frame: the frame is discarded and outputs return to reset values immediately.

Test Plan:
- Reset/idle: RSTN=0, then release with CFG_EN=0 for 20 cycles.
  -> TSMUX_O=12'h000, DORREG_O=6'h00, CFG_BUSY=0, CFG_DONE=0, CFG_ERR=0.
- Good frame: send A5, then 6 triples of 0,1,1, then parity 0.
  -> one edge after the parity bit: TSMUX_O=12'h555, DORREG_O=6'h3F, CFG_DONE=1, CFG_BUSY=0.
- Parity error: after the good frame, send A5, then 18 zero payload bits, then parity 1.
  -> CFG_ERR=1, CFG_DONE=0, TSMUX_O stays 12'h555, DORREG_O stays 6'h3F.
- Stall and overlapping sync:
  - Stream 1,0,1,0,0,1,0,1 preceded by the pattern 1,0,1 (so A5 completes only at the final bit).
  - Then a frame with IOB 5 = 1,1,0 and all other IOBs zero, parity 0, with CFG_EN toggled low every other cycle.
  -> TSMUX_O=12'hC00, DORREG_O=6'h00, CFG_DONE=1.
- Abort: CFG_ABORT=1 after 10 payload bits.
  -> CFG_BUSY=0 next edge; outputs and flags unchanged.
  -> a following complete good frame commits normally.
- Async reset mid-LOAD: RSTN low between clock edges.
  -> all outputs zero without waiting for a clock edge.
  -> after release, the FSM needs a fresh A5 before it will load.

Source files
------------

// File: rtl/iob_cfg_loader.sv
// Serial configuration loader for the IO block bank: finds the sync word, shifts in one
// payload frame, checks even parity and commits the per-pad TSMUX/DORREG fields in a single update.
//
// state  | meaning
// HUNT   | shifting consumed bits through the sync window, looking for SYNC_WORD
// LOAD   | shifting 3*NUM_IOB payload bits into the shadow register
// PARITY | consuming the even-parity bit that closes the frame
// COMMIT | one cycle: copy shadow to outputs (good) or flag error (bad)
module iob_cfg_loader #(
    parameter int          NUM_IOB   = 6,
    parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
    input  logic                   IOCLK,
    input  logic                   RSTN,
    input  logic                   CFG_EN,
    input  logic                   CFG_DIN,
    input  logic                   CFG_ABORT,
    output logic [2*NUM_IOB-1:0]   TSMUX_O,
    output logic [NUM_IOB-1:0]     DORREG_O,
    output logic                   CFG_BUSY,
    output logic                   CFG_DONE,
    output logic                   CFG_ERR
);

    localparam int NBITS = 3 * NUM_IOB;
    localparam int CW    = $clog2(NBITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOAD   = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t               state;
    logic [7:0]           window;
    logic [7:0]           window_nx;
    logic [NBITS-1:0]     shadow;
    logic [CW-1:0]        cnt;
    logic                 par;
    logic [2*NUM_IOB-1:0] tsm_nx;
    logic [NUM_IOB-1:0]   dor_nx;

    assign window_nx = {window[6:0], CFG_DIN};
    assign CFG_BUSY  = (state != HUNT);

    // The first payload bit ends up at the shadow MSB, so IOB 0 sits at the top.
    always_comb begin
        tsm_nx = '0;
        dor_nx = '0;
        for (int i = 0; i < NUM_IOB; i++) begin
            tsm_nx[2*i+1] = shadow[NBITS-1-3*i];
            tsm_nx[2*i]   = shadow[NBITS-2-3*i];
            dor_nx[i]     = shadow[NBITS-3-3*i];
        end
    end

    always_ff @(posedge IOCLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= HUNT;
            window   <= '0;
            shadow   <= '0;
            cnt      <= '0;
            par      <= 1'b0;
            TSMUX_O  <= '0;
            DORREG_O <= '0;
            CFG_DONE <= 1'b0;
            CFG_ERR  <= 1'b0;
        end else if (CFG_ABORT) begin
            state  <= HUNT;
            window <= '0;
            shadow <= '0;
            cnt    <= '0;
            par    <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (CFG_EN) begin
                        window <= window_nx;
                        if (window_nx == SYNC_WORD) begin
                            state    <= LOAD;
                            cnt      <= '0;
                            par      <= 1'b0;
                            CFG_DONE <= 1'b0;
                            CFG_ERR  <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (CFG_EN) begin
                        shadow <= {shadow[NBITS-2:0], CFG_DIN};
                        par    <= par ^ CFG_DIN;
                        if (cnt == CNT_LAST) begin
                            state <= PARITY;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (CFG_EN) begin
                        par   <= par ^ CFG_DIN;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (!par) begin
                        TSMUX_O  <= tsm_nx;
                        DORREG_O <= dor_nx;
                        CFG_DONE <= 1'b1;
                    end else begin
                        CFG_ERR <= 1'b1;
                    end
                    window <= '0;
                    cnt    <= '0;
                    state  <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cfg_loader.sv
// Randomized bench for iob_cfg_loader: a queue-based frame model is compared against the
// DUT on every falling edge, with literal expectations pinning the directed scenarios.
module tb_iob_cfg_loader;

    localparam int N     = 6;
    localparam int NBITS = 3 * N;

    logic            IOCLK = 1'b0;
    logic            RSTN  = 1'b0;
    logic            CFG_EN = 1'b0;
    logic            CFG_DIN = 1'b0;
    logic            CFG_ABORT = 1'b0;
    logic [2*N-1:0]  TSMUX_O;
    logic [N-1:0]    DORREG_O;
    logic            CFG_BUSY;
    logic            CFG_DONE;
    logic            CFG_ERR;

    iob_cfg_loader #(.NUM_IOB(N), .SYNC_WORD(8'hA5)) dut (
        .IOCLK    (IOCLK),
        .RSTN     (RSTN),
        .CFG_EN   (CFG_EN),
        .CFG_DIN  (CFG_DIN),
        .CFG_ABORT(CFG_ABORT),
        .TSMUX_O  (TSMUX_O),
        .DORREG_O (DORREG_O),
        .CFG_BUSY (CFG_BUSY),
        .CFG_DONE (CFG_DONE),
        .CFG_ERR  (CFG_ERR)
    );

    initial forever #5 IOCLK = ~IOCLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: sync hunt via an integer window, frame collected into a queue.
    bit             m_sync;
    bit             m_pend;
    int             m_win;
    bit             m_pl[$];
    logic [2*N-1:0] m_tsm;
    logic [N-1:0]   m_dor;
    logic           m_done;
    logic           m_err;

    function automatic void model_reset();
        m_sync = 0; m_pend = 0; m_win = 0; m_pl.delete();
        m_tsm = '0; m_dor = '0; m_done = 0; m_err = 0;
    endfunction

    function automatic void model_edge(input bit en, input bit din, input bit ab);
        bit x;
        if (ab) begin
            m_sync = 0; m_pend = 0; m_win = 0; m_pl.delete();
        end else if (m_pend) begin
            x = 0;
            foreach (m_pl[k]) x ^= m_pl[k];
            if (x == 0) begin
                for (int i = 0; i < N; i++) begin
                    m_tsm[2*i+1] = m_pl[3*i];
                    m_tsm[2*i]   = m_pl[3*i+1];
                    m_dor[i]     = m_pl[3*i+2];
                end
                m_done = 1;
            end else begin
                m_err = 1;
            end
            m_pend = 0; m_sync = 0; m_win = 0; m_pl.delete();
        end else if (en) begin
            if (!m_sync) begin
                m_win = ((m_win << 1) | int'(din)) & 8'hFF;
                if (m_win == 8'hA5) begin
                    m_sync = 1; m_done = 0; m_err = 0; m_pl.delete();
                end
            end else begin
                m_pl.push_back(din);
                if (m_pl.size() == NBITS + 1) m_pend = 1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge IOCLK) begin
        if (chk_en && RSTN) begin
            chk("cyc_tsmux",  32'(TSMUX_O),  32'(m_tsm));
            chk("cyc_dorreg", 32'(DORREG_O), 32'(m_dor));
            chk("cyc_busy",   32'(CFG_BUSY), 32'(m_sync || m_pend));
            chk("cyc_done",   32'(CFG_DONE), 32'(m_done));
            chk("cyc_err",    32'(CFG_ERR),  32'(m_err));
        end
    end

    task automatic step(input bit en, input bit din, input bit ab);
        CFG_EN = en; CFG_DIN = din; CFG_ABORT = ab;
        @(posedge IOCLK);
        if (RSTN) model_edge(en, din, ab);
        #1;
    endtask

    task automatic send_bit(input bit b, input int stall_pct);
        for (int s = 0; s < 4 && int'($urandom_range(99)) < stall_pct; s++)
            step(1'b0, 1'($urandom), 1'b0);
        step(1'b1, b, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v, input int stall_pct);
        for (int i = 7; i >= 0; i--) send_bit(v[i], stall_pct);
    endtask

    task automatic send_frame(input logic [NBITS-1:0] pl, input bit bad, input int stall_pct);
        send_byte(8'hA5, stall_pct);
        for (int k = 0; k < NBITS; k++) send_bit(pl[k], stall_pct);
        send_bit((^pl) ^ bad, stall_pct);
        step(1'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        logic [NBITS-1:0] pl;
        logic [10:0]      pre;

        model_reset();
        repeat (3) @(posedge IOCLK);
        #1;
        chk("rst_tsmux", 32'(TSMUX_O), 32'h0);
        chk("rst_flags", 32'({CFG_BUSY, CFG_DONE, CFG_ERR}), 32'h0);
        RSTN = 1'b1;
        chk_en = 1'b1;
        repeat (20) step(1'b0, 1'($urandom), 1'b0);
        chk("idle_tsmux",  32'(TSMUX_O),  32'h000);
        chk("idle_dorreg", 32'(DORREG_O), 32'h00);
        chk("idle_flags",  32'({CFG_BUSY, CFG_DONE, CFG_ERR}), 32'h0);

        // Good frame: every IOB = 0,1,1
        for (int i = 0; i < N; i++) begin
            pl[3*i] = 1'b0; pl[3*i+1] = 1'b1; pl[3*i+2] = 1'b1;
        end
        send_byte(8'hA5, 0);
        for (int k = 0; k < NBITS; k++) send_bit(pl[k], 0);
        send_bit(1'b0, 0);
        chk("good_busy_at_parity", 32'(CFG_BUSY), 32'h1);
        chk("good_no_early_update", 32'(TSMUX_O), 32'h000);
        step(1'b0, 1'b0, 1'b0);
        chk("good_tsmux",  32'(TSMUX_O),  32'h555);
        chk("good_dorreg", 32'(DORREG_O), 32'h3F);
        chk("good_done",   32'(CFG_DONE), 32'h1);
        chk("good_busy",   32'(CFG_BUSY), 32'h0);
        chk("model_good_tsmux", 32'(m_tsm), 32'h555);

        // Parity error frame
        send_frame('0, 1'b1, 0);
        chk("perr_err",    32'(CFG_ERR),  32'h1);
        chk("perr_done",   32'(CFG_DONE), 32'h0);
        chk("perr_tsmux",  32'(TSMUX_O),  32'h555);
        chk("perr_dorreg", 32'(DORREG_O), 32'h3F);

        // Overlapping sync: 1,0,1 then 1,0,1,0,0,1,0,1 completes A5 only at the last bit
        pre = 11'b101_1010_0101;
        for (int i = 10; i >= 1; i--) send_bit(pre[i], 0);
        chk("ovl_busy_before", 32'(CFG_BUSY), 32'h0);
        send_bit(pre[0], 0);
        chk("ovl_busy_after", 32'(CFG_BUSY), 32'h1);
        chk("ovl_err_cleared", 32'(CFG_ERR), 32'h0);
        pl = '0;
        pl[15] = 1'b1; pl[16] = 1'b1;
        for (int k = 0; k < NBITS; k++) begin
            step(1'b0, 1'($urandom), 1'b0);
            step(1'b1, pl[k], 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("stall_tsmux",  32'(TSMUX_O),  32'hC00);
        chk("stall_dorreg", 32'(DORREG_O), 32'h00);
        chk("stall_done",   32'(CFG_DONE), 32'h1);

        // Abort after 10 payload bits
        send_byte(8'hA5, 0);
        for (int k = 0; k < 10; k++) send_bit(1'b1, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("abort_busy",  32'(CFG_BUSY), 32'h0);
        chk("abort_tsmux", 32'(TSMUX_O),  32'hC00);
        chk("abort_flags", 32'({CFG_DONE, CFG_ERR}), 32'h0);
        pl = NBITS'($urandom);
        pl[0] = 1'b1;
        send_frame(pl, 1'b0, 30);
        chk("post_abort_done", 32'(CFG_DONE), 32'h1);

        // Async reset in the middle of LOAD
        send_byte(8'hA5, 0);
        for (int k = 0; k < 5; k++) send_bit(1'($urandom), 0);
        #2;
        RSTN = 1'b0;
        model_reset();
        #1;
        chk("arst_tsmux",  32'(TSMUX_O),  32'h0);
        chk("arst_dorreg", 32'(DORREG_O), 32'h0);
        chk("arst_flags",  32'({CFG_BUSY, CFG_DONE, CFG_ERR}), 32'h0);
        @(posedge IOCLK);
        #1;
        RSTN = 1'b1;
        for (int k = 0; k < 20; k++) send_bit(1'b1, 0);
        chk("arst_needs_sync", 32'(CFG_BUSY), 32'h0);
        send_frame(NBITS'($urandom), 1'b0, 0);
        chk("arst_then_done", 32'(CFG_DONE), 32'h1);

        // Randomized traffic: junk, frames, stalls, occasional aborts and bad parity
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < int'($urandom_range(12)); j++)
                step(1'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(5) == 0) begin
                send_byte(8'hA5, 20);
                for (int k = 0; k < int'($urandom_range(NBITS + 1)); k++)
                    send_bit(1'($urandom), 20);
                step(1'($urandom), 1'($urandom), 1'b1);
            end else begin
                send_frame(NBITS'($urandom), ($urandom_range(3) == 0), 25);
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
